pcm_capture_ctrl: RTL and testbench
===================================

Name: pcm_capture_ctrl

Overview:
- Sequences recording of the 16-bit PCM stream produced by the I2S front end (tdata_pcm/tvalid_pcm, system clk domain).
- Arms on a software start, waits for a level trigger, captures exactly N samples into an internal FIFO, and drains them on an AXI-stream master with backpressure and tlast.
- Sits between the I2S-to-PCM converter and the downstream consumer (DMA/UART packetiser), and owns capture status.

Parameters:
- DEPTH, 1024, FIFO depth in samples; must be a power of two, ≥4.
- CNT_W, 16, width of the sample-count request and the counters.

Ports:
- clk  input  1  system clock; the only clock.
- arstn  input  1  asynchronous, active-low reset.
- s_pcm_data  input  16  signed PCM sample (from tdata_pcm).
- s_pcm_valid  input  1  one-cycle sample strobe; the source cannot stall.
- start  input  1  one-cycle pulse: latch the config and arm.
- abort  input  1  one-cycle pulse: cancel the capture from any state.
- threshold  input  16  unsigned trigger level, latched on start.
- num_samples  input  CNT_W  number of samples to capture, latched on start.
- m_tdata  output  16  captured sample.
- m_tvalid  output  1  AXI-stream valid.
- m_tready  input  1  AXI-stream ready.
- m_tlast  output  1  high on the num_samples-th output beat.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at normal completion.
- overflow  output  1  sticky: at least one sample was dropped because the FIFO was full.

Behaviour:
- Reset (arstn low, asynchronous):
  - State becomes IDLE and the FIFO pointers are cleared.
  - m_tvalid, m_tlast, busy, done and overflow are 0; m_tdata is 0.
- States: IDLE, ARMED, CAPTURE, FLUSH.
- IDLE:
  - On start with num_samples != 0: latch threshold and num_samples, clear overflow and both counters, go to ARMED.
  - On start with num_samples == 0: stay in IDLE and pulse done on the next cycle.
- ARMED:
  - On each s_pcm_valid, compute a 17-bit |s_pcm_data|; |-32768| = 32768.
  - If |sample| ≥ threshold: that sample is written to the FIFO as capture #1 and the state goes to CAPTURE (or to FLUSH if num_samples == 1).
  - threshold = 0 triggers on the first sample.
- CAPTURE:
  - Every s_pcm_valid writes the sample to the FIFO if the FIFO is not full.
  - If the FIFO is full, the sample is dropped, overflow is set, and the sample is not counted.
  - When the write count reaches num_samples, go to FLUSH; later samples are ignored.
- FLUSH: when the FIFO is empty and the last beat has handshaken, pulse done and go to IDLE.
- Output drain:
  - Runs concurrently in CAPTURE and FLUSH.
  - A beat transfers when m_tvalid && m_tready.
  - m_tdata and m_tlast are held stable while m_tvalid && !m_tready.
  - m_tlast = 1 exactly when the read count equals num_samples - 1 before the transfer.
- Latency: a sample written at cycle t appears on m_tvalid no earlier than t+2, given an empty FIFO and m_tready high.
- FIFO:
  - Full at DEPTH entries; pointers are log2(DEPTH)+1 bits wide and wrap.
  - A simultaneous write and read when full: the read frees an entry the same cycle, so the write is accepted and there is no overflow.
- start while busy: ignored; the latched configuration is unchanged.
- abort:
  - Takes effect next cycle from any state: go to IDLE, empty the FIFO, drop m_tvalid, no done.
  - A mid-packet abort is allowed to truncate the stream.
  - overflow keeps its value until the next accepted start.
- Simultaneous start and abort in IDLE: abort wins and the start is ignored.
- Reset mid-capture: same as power-on reset.

Test Plan:
- Basic capture: threshold=100, num_samples=8; feed 5 samples of 0, then 8 samples of 200..207, with m_tready=1 → 8 beats 200..207, tlast on 207, done a single pulse, overflow=0.
- Trigger edge cases:
  - threshold=32768 with an input of -32768 → triggers.
  - threshold=0 → the first sample is captured.
- Backpressure/overflow: DEPTH=4, num_samples=10, m_tready=0 for 6 sample strobes, then m_tready=1 → overflow=1, 2 samples dropped, 10 beats total with tlast on the 10th.
- Full with simultaneous read: FIFO full, and a write and a read occur in the same cycle → sample accepted, overflow stays 0.
- Abort mid-drain: after 3 of 8 beats, pulse abort → m_tvalid=0 next cycle, busy=0, no done; a new start then captures normally.
- Zero-length and busy start: start with num_samples=0 → done pulse, busy stays 0; a second start during CAPTURE → ignored, the original count is honoured.

Source files
------------

// File: rtl/pcm_capture_ctrl.sv
// Triggered PCM capture: arms on start, waits for |sample| >= threshold, stores exactly
// num_samples samples in a FIFO and drains them on an AXI-stream master with tlast.
module pcm_capture_ctrl #(
    parameter int DEPTH = 1024,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic [15:0]      s_pcm_data,
    input  logic             s_pcm_valid,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      threshold,
    input  logic [CNT_W-1:0] num_samples,
    output logic [15:0]      m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic             m_tlast,
    output logic             busy,
    output logic             done,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      DEPTH_P = (AW+1)'(DEPTH);
    localparam logic [AW:0]      PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    // 17-bit magnitude so that -32768 maps to 32768 without wrapping.
    function automatic logic [16:0] abs17(input logic [15:0] v);
        logic [16:0] ext;
        ext = {v[15], v};
        if (v[15]) begin
            return (~ext) + 17'd1;
        end else begin
            return ext;
        end
    endfunction

    state_t           state_r;
    logic [15:0]      thr_r;
    logic [CNT_W-1:0] num_r;
    logic [CNT_W-1:0] wr_cnt_r;
    logic [CNT_W-1:0] rd_cnt_r;
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [15:0]      m_tdata_r;
    logic             m_tvalid_r;
    logic             m_tlast_r;
    logic             busy_r;
    logic             done_r;
    logic             overflow_r;
    logic [15:0]      mem_r [DEPTH];

    logic             hs_s;
    logic [AW:0]      count_s;
    logic [AW:0]      avail_s;
    logic [AW:0]      rd_ptr_nxt_s;
    logic [CNT_W-1:0] rd_cnt_nxt_s;
    logic [CNT_W-1:0] wr_cnt_inc_s;
    logic [CNT_W-1:0] num_m1_s;
    logic             full_s;
    logic             trig_s;
    logic             cap_wr_s;
    logic             drop_s;
    logic             wr_en_s;
    logic             drain_s;
    logic             last_done_s;

    // The presented beat stays in the FIFO until it handshakes, so a pop frees a slot
    // in the same cycle and the full FIFO can still accept a write.
    assign hs_s         = m_tvalid_r && m_tready;
    assign count_s      = wr_ptr_r - rd_ptr_r;
    assign full_s       = (count_s == DEPTH_P);
    assign avail_s      = count_s - {{AW{1'b0}}, hs_s};
    assign rd_ptr_nxt_s = rd_ptr_r + {{AW{1'b0}}, hs_s};
    assign rd_cnt_nxt_s = rd_cnt_r + {{(CNT_W-1){1'b0}}, hs_s};
    assign wr_cnt_inc_s = wr_cnt_r + CNT_ONE;
    assign num_m1_s     = num_r - CNT_ONE;
    assign trig_s       = (state_r == ARMED) && s_pcm_valid && (abs17(s_pcm_data) >= {1'b0, thr_r});
    assign cap_wr_s     = (state_r == CAPTURE) && s_pcm_valid && (!full_s || hs_s);
    assign drop_s       = (state_r == CAPTURE) && s_pcm_valid && full_s && !hs_s;
    assign wr_en_s      = trig_s || cap_wr_s;
    assign drain_s      = (state_r == CAPTURE) || (state_r == FLUSH);
    assign last_done_s  = (state_r == FLUSH) && hs_s && m_tlast_r && (avail_s == {(AW+1){1'b0}});

    // FIFO storage; only the pointers need reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !abort) begin
            mem_r[wr_ptr_r[AW-1:0]] <= s_pcm_data;
        end
    end

    // Capture sequencer, FIFO pointers and registered stream outputs.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_r    <= IDLE;
            thr_r      <= 16'd0;
            num_r      <= {CNT_W{1'b0}};
            wr_cnt_r   <= {CNT_W{1'b0}};
            rd_cnt_r   <= {CNT_W{1'b0}};
            wr_ptr_r   <= {(AW+1){1'b0}};
            rd_ptr_r   <= {(AW+1){1'b0}};
            m_tdata_r  <= 16'd0;
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort) begin
                state_r    <= IDLE;
                busy_r     <= 1'b0;
                wr_ptr_r   <= {(AW+1){1'b0}};
                rd_ptr_r   <= {(AW+1){1'b0}};
                m_tvalid_r <= 1'b0;
                m_tlast_r  <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start && (num_samples != {CNT_W{1'b0}})) begin
                            thr_r      <= threshold;
                            num_r      <= num_samples;
                            overflow_r <= 1'b0;
                            wr_cnt_r   <= {CNT_W{1'b0}};
                            rd_cnt_r   <= {CNT_W{1'b0}};
                            wr_ptr_r   <= {(AW+1){1'b0}};
                            rd_ptr_r   <= {(AW+1){1'b0}};
                            state_r    <= ARMED;
                            busy_r     <= 1'b1;
                        end else if (start) begin
                            done_r <= 1'b1;
                        end
                    end
                    ARMED: begin
                        if (trig_s) begin
                            wr_ptr_r <= wr_ptr_r + PTR_ONE;
                            wr_cnt_r <= CNT_ONE;
                            state_r  <= (num_r == CNT_ONE) ? FLUSH : CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        if (cap_wr_s) begin
                            wr_ptr_r <= wr_ptr_r + PTR_ONE;
                            wr_cnt_r <= wr_cnt_inc_s;
                            if (wr_cnt_inc_s == num_r) begin
                                state_r <= FLUSH;
                            end
                        end
                        if (drop_s) begin
                            overflow_r <= 1'b1;
                        end
                    end
                    FLUSH: begin
                        if (last_done_s) begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end
                endcase

                if (drain_s) begin
                    rd_ptr_r <= rd_ptr_nxt_s;
                    rd_cnt_r <= rd_cnt_nxt_s;
                    if (avail_s != {(AW+1){1'b0}}) begin
                        m_tvalid_r <= 1'b1;
                        m_tdata_r  <= mem_r[rd_ptr_nxt_s[AW-1:0]];
                        m_tlast_r  <= (rd_cnt_nxt_s == num_m1_s);
                    end else begin
                        m_tvalid_r <= 1'b0;
                        m_tlast_r  <= 1'b0;
                    end
                end else begin
                    m_tvalid_r <= 1'b0;
                    m_tlast_r  <= 1'b0;
                end
            end
        end
    end

    assign m_tdata  = m_tdata_r;
    assign m_tvalid = m_tvalid_r;
    assign m_tlast  = m_tlast_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign overflow = overflow_r;
endmodule

// File: tb/tb_pcm_capture_ctrl.sv
// Randomized bench for pcm_capture_ctrl against a queue-based reference of the capture rules.
module tb_pcm_capture_ctrl;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
    localparam int M_IDLE = 0, M_ARMED = 1, M_CAP = 2, M_FLUSH = 3;

    logic             clk = 1'b0;
    logic             arstn;
    logic [15:0]      s_pcm_data;
    logic             s_pcm_valid;
    logic             start;
    logic             abort;
    logic [15:0]      threshold;
    logic [CNT_W-1:0] num_samples;
    logic [15:0]      m_tdata;
    logic             m_tvalid;
    logic             m_tready;
    logic             m_tlast;
    logic             busy;
    logic             done;
    logic             overflow;

    always #5 clk = ~clk;

    pcm_capture_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .arstn(arstn), .s_pcm_data(s_pcm_data), .s_pcm_valid(s_pcm_valid),
        .start(start), .abort(abort), .threshold(threshold), .num_samples(num_samples),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .busy(busy), .done(done), .overflow(overflow)
    );

    typedef struct {
        logic [15:0] d;
        int          t;
    } ent_t;

    ent_t q[$];
    int   checks_n = 0;
    int   errors_n = 0;
    int   mode, wcnt, bcnt, ecnt, thr, num;
    int   beats_seen = 0;
    int   done_seen = 0;
    logic ovf, exp_done;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_n++;
        if (got !== exp) begin
            errors_n++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int mag(input logic [15:0] d);
        int v;
        v = int'($signed(d));
        return (v < 0) ? -v : v;
    endfunction

    task automatic model_reset();
        mode = M_IDLE;
        q.delete();
        ovf = 1'b0;
        exp_done = 1'b0;
        wcnt = 0;
        bcnt = 0;
    endtask

    // One clock: apply the reference rules to the pre-edge inputs, then check after the edge.
    task automatic tick();
        logic        hs, stall, hl, ab;
        logic [15:0] hd;
        ent_t        e;
        hs = m_tvalid && m_tready;
        stall = m_tvalid && !m_tready;
        hd = m_tdata;
        hl = m_tlast;
        ab = abort;
        if (m_tvalid) begin
            check_eq("valid_has_data", q.size() != 0, 1);
            if (q.size() != 0) check_eq("latency", q[0].t <= ecnt - 2, 1);
        end
        if (hs) begin
            beats_seen++;
            if (q.size() != 0) begin
                e = q.pop_front();
                check_eq("beat_data", m_tdata, e.d);
                check_eq("beat_last", m_tlast, bcnt == num - 1);
                bcnt++;
            end
        end
        exp_done = 1'b0;
        if (abort) begin
            mode = M_IDLE;
            q.delete();
        end else begin
            case (mode)
                M_IDLE: if (start) begin
                    if (num_samples == 0) exp_done = 1'b1;
                    else begin
                        thr = int'(threshold); num = int'(num_samples);
                        ovf = 1'b0; wcnt = 0; bcnt = 0; q.delete();
                        mode = M_ARMED;
                    end
                end
                M_ARMED: if (s_pcm_valid && mag(s_pcm_data) >= thr) begin
                    e.d = s_pcm_data; e.t = ecnt; q.push_back(e);
                    wcnt = 1;
                    mode = (num == 1) ? M_FLUSH : M_CAP;
                end
                M_CAP: if (s_pcm_valid) begin
                    if (q.size() < DEPTH) begin
                        e.d = s_pcm_data; e.t = ecnt; q.push_back(e);
                        wcnt++;
                        if (wcnt == num) mode = M_FLUSH;
                    end else ovf = 1'b1;
                end
                M_FLUSH: if (hs && bcnt == num) begin
                    mode = M_IDLE;
                    exp_done = 1'b1;
                end
                default: mode = M_IDLE;
            endcase
        end
        ecnt++;
        @(posedge clk);
        #1;
        done_seen += int'(done);
        check_eq("busy", busy, mode != M_IDLE);
        check_eq("done", done, exp_done);
        check_eq("overflow", overflow, ovf);
        if (mode == M_IDLE) check_eq("idle_valid", m_tvalid, 0);
        if (stall && !ab) begin
            check_eq("hold_valid", m_tvalid, 1);
            check_eq("hold_data", m_tdata, hd);
            check_eq("hold_last", m_tlast, hl);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic strobe(input logic [15:0] d, input int gap);
        s_pcm_valid = 1'b1;
        s_pcm_data = d;
        tick();
        s_pcm_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_start(input logic [15:0] t, input int n);
        threshold = t;
        num_samples = CNT_W'(n);
        start = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input int budget, input bit rand_ready);
        int n = 0;
        while ((busy || mode != M_IDLE) && n < budget) begin
            s_pcm_valid = ($urandom_range(0, 1) == 0);
            s_pcm_data = 16'($urandom);
            if (rand_ready) m_tready = ($urandom_range(0, 9) < 7);
            tick();
            n++;
        end
        s_pcm_valid = 1'b0;
        check_eq("timeout", n < budget, 1);
    endtask

    task automatic apply_reset_check(input string tag);
        arstn = 1'b0;
        #1;
        check_eq({tag, "_tvalid"}, m_tvalid, 0);
        check_eq({tag, "_tlast"}, m_tlast, 0);
        check_eq({tag, "_tdata"}, m_tdata, 0);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_ovf"}, overflow, 0);
        model_reset();
        @(negedge clk);
        arstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, d0, n;
        arstn = 1'b1; s_pcm_data = 16'd0; s_pcm_valid = 1'b0; start = 1'b0; abort = 1'b0;
        threshold = 16'd0; num_samples = '0; m_tready = 1'b0; ecnt = 0;
        thr = 0; num = 0;
        #2;
        apply_reset_check("rst");

        // Basic capture: five quiet samples then 200..207.
        m_tready = 1'b1;
        b0 = beats_seen; d0 = done_seen;
        do_start(16'd100, 8);
        for (int i = 0; i < 5; i++) strobe(16'd0, $urandom_range(0, 3));
        for (int i = 0; i < 8; i++) strobe(16'(200 + i), $urandom_range(0, 3));
        wait_idle(200, 1'b0);
        check_eq("basic_beats", beats_seen - b0, 8);
        check_eq("basic_done_pulses", done_seen - d0, 1);
        check_eq("basic_ovf", overflow, 0);

        // Threshold 32768 only fires on -32768.
        b0 = beats_seen;
        do_start(16'h8000, 1);
        strobe(16'h7fff, 1); strobe(16'h8001, 1); strobe(16'h8000, 1);
        wait_idle(50, 1'b0);
        check_eq("neg_full_scale_beats", beats_seen - b0, 1);

        // Threshold 0: the first sample is taken.
        b0 = beats_seen;
        do_start(16'd0, 3);
        for (int i = 0; i < 3; i++) strobe(16'($urandom), $urandom_range(0, 2));
        wait_idle(50, 1'b0);
        check_eq("thr0_beats", beats_seen - b0, 3);

        // Backpressure overflow: six strobes with the sink stalled.
        m_tready = 1'b0;
        b0 = beats_seen;
        do_start(16'd0, 10);
        for (int i = 0; i < 6; i++) strobe(16'($urandom), 1);
        check_eq("ovf_set", overflow, 1);
        m_tready = 1'b1;
        wait_idle(300, 1'b0);
        check_eq("ovf_beats", beats_seen - b0, 10);
        check_eq("ovf_sticky", overflow, 1);

        // Full FIFO with a write and a read in the same cycle.
        m_tready = 1'b0;
        do_start(16'd0, 12);
        for (int i = 0; i < 4; i++) strobe(16'($urandom), 1);
        tick(); tick();
        m_tready = 1'b1;
        strobe(16'h1234, 0);
        m_tready = 1'b0;
        check_eq("full_rw_ovf", overflow, 0);
        tick();
        m_tready = 1'b1;
        wait_idle(300, 1'b0);
        check_eq("full_rw_ovf_end", overflow, 0);

        // Abort after three beats, then a clean capture.
        m_tready = 1'b0;
        d0 = done_seen;
        do_start(16'd0, 8);
        for (int i = 0; i < 4; i++) strobe(16'($urandom), 0);
        m_tready = 1'b1;
        b0 = beats_seen; n = 0;
        while (beats_seen - b0 < 3 && n < 100) begin tick(); n++; end
        check_eq("abort_wait", n < 100, 1);
        abort = 1'b1;
        tick();
        check_eq("abort_tvalid", m_tvalid, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_no_done", done_seen - d0, 0);
        b0 = beats_seen;
        do_start(16'd50, 4);
        wait_idle(300, 1'b0);
        check_eq("post_abort_beats", beats_seen - b0, 4);

        // Zero-length start, then a start while capturing.
        do_start(16'd0, 0);
        check_eq("zero_done", done, 1);
        check_eq("zero_busy", busy, 0);
        b0 = beats_seen;
        do_start(16'd0, 5);
        strobe(16'd7, 0); strobe(16'd8, 0);
        do_start(16'd0, 2);
        wait_idle(200, 1'b0);
        check_eq("busy_start_beats", beats_seen - b0, 5);

        // Start and abort together in IDLE.
        threshold = 16'd0; num_samples = CNT_W'(3); start = 1'b1; abort = 1'b1;
        tick();
        check_eq("start_abort_busy", busy, 0);
        tick();

        // Reset in the middle of a capture.
        do_start(16'd0, 6);
        strobe(16'd1, 0); strobe(16'd2, 0);
        apply_reset_check("midrst");
        b0 = beats_seen;
        do_start(16'd0, 2);
        wait_idle(100, 1'b0);
        check_eq("post_rst_beats", beats_seen - b0, 2);

        // Random captures with random backpressure and occasional abort.
        for (int r = 0; r < 20; r++) begin
            do_start(16'($urandom_range(0, 30000)), $urandom_range(1, 12));
            n = 0;
            while ((busy || mode != M_IDLE) && n < 600) begin
                s_pcm_valid = ($urandom_range(0, 2) == 0);
                s_pcm_data = 16'($urandom);
                m_tready = ($urandom_range(0, 9) < 6);
                abort = ($urandom_range(0, 199) == 0);
                tick();
                n++;
            end
            s_pcm_valid = 1'b0;
            check_eq("rand_timeout", n < 600, 1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
        $finish;
    end
endmodule
